// File: rtl/pattern_tx_if.sv
// Parallel frame-request channel between a word source and pattern_tx.
// The source drives the request fields; the transmitter returns load_ready.
interface pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LENW  = $clog2(WIDTH + 1)
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LENW-1:0]  load_len;
    logic [3:0]       load_rep;

    modport master (
        output load_valid, load_data, load_len, load_rep,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_data, load_len, load_rep,
        output load_ready
    );
endinterface

// File: rtl/pattern_tx.sv
// Serial transmitter: "01" preamble plus up to WIDTH data bits MSB first,
// optionally repeated; the line idles high between frames.
module pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LENW  = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    pattern_tx_if.slave  load,
    output logic         a,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE0 = 3'd1,
        PRE1 = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_shadow_data;
    logic [LENW-1:0]  r_len;
    logic [LENW-1:0]  r_shadow_len;
    logic [LENW-1:0]  r_bit_cnt;
    logic [3:0]       r_rep_cnt;
    logic             w_accept;
    logic [LENW-1:0]  w_len_clamped;

    assign w_accept      = load.load_valid && (r_state == IDLE);
    assign w_len_clamped = (load.load_len > LENW'(WIDTH)) ? LENW'(WIDTH) : load.load_len;
    assign load.load_ready = (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        a            = 1'b1;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_accept) w_state_next = PRE0;
            end
            PRE0: begin
                a            = 1'b0;
                w_state_next = PRE1;
            end
            PRE1: begin
                w_state_next = (r_len != '0) ? DATA : GAP;
            end
            DATA: begin
                a = r_shreg[WIDTH-1];
                if (r_bit_cnt == LENW'(1)) w_state_next = GAP;
            end
            GAP: begin
                done         = (r_rep_cnt == '0);
                w_state_next = (r_rep_cnt != '0) ? PRE0 : IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // Shadow copies let each repetition replay the frame captured at accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg       <= '0;
            r_shadow_data <= '0;
            r_len         <= '0;
            r_shadow_len  <= '0;
            r_bit_cnt     <= '0;
            r_rep_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg       <= load.load_data;
                        r_shadow_data <= load.load_data;
                        r_len         <= w_len_clamped;
                        r_shadow_len  <= w_len_clamped;
                        r_rep_cnt     <= load.load_rep;
                    end
                end
                PRE1: begin
                    r_bit_cnt <= r_len;
                end
                DATA: begin
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= r_bit_cnt - LENW'(1);
                end
                GAP: begin
                    if (r_rep_cnt != '0) begin
                        r_rep_cnt <= r_rep_cnt - 4'd1;
                        r_shreg   <= r_shadow_data;
                        r_len     <= r_shadow_len;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx: each accepted request queues the expected
// per-cycle {a, busy, done, load_ready} stream, compared on the falling edge.
module tb_pattern_tx;

    localparam int WIDTH = 8;
    localparam int LENW  = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;
    logic a, busy, done;

    pattern_tx_if #(.WIDTH(WIDTH), .LENW(LENW)) load_bus ();

    pattern_tx #(.WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load_bus.slave),
        .a     (a),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [3:0]  sb[$];
    logic        mon_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Moore "01" detector watching the serial line
    logic [1:0]  det_st;
    logic        det_y;
    int unsigned det_hits = 0;
    assign det_y = (det_st == 2'd2);

    always @(posedge clk or posedge reset) begin
        if (reset) det_st <= 2'd0;
        else if (!a) det_st <= 2'd1;
        else det_st <= (det_st == 2'd1) ? 2'd2 : 2'd0;
    end

    always @(negedge clk) if (det_y) det_hits++;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (sb.size() > 0) check("frame", {a, busy, done, load_bus.load_ready}, sb.pop_front());
            else check("idle", {a, busy, done, load_bus.load_ready}, 4'b1001);
        end
    end

    task automatic push_frame(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        int unsigned len;
        logic [7:0]  dd;
        len = (l > 4'd8) ? 8 : int'(l);
        dd  = d;
        for (int k = 0; k <= int'(r); k++) begin
            sb.push_back(4'b0100);
            sb.push_back(4'b1100);
            for (int i = 0; i < int'(len); i++) sb.push_back({dd[7 - i], 3'b100});
            sb.push_back({2'b11, (k == int'(r)), 1'b0});
        end
    endtask

    task automatic scramble();
        load_bus.load_data = 8'($urandom);
        load_bus.load_len  = 4'($urandom);
        load_bus.load_rep  = 4'($urandom);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r, input bit keep);
        int unsigned n = 0;
        @(negedge clk);
        while (!load_bus.load_ready) begin
            scramble();
            @(negedge clk);
            n++;
            if (n > 500) begin
                check("ready_timeout", 0, 1);
                return;
            end
        end
        load_bus.load_valid = 1'b1;
        load_bus.load_data  = d;
        load_bus.load_len   = l;
        load_bus.load_rep   = r;
        @(posedge clk);
        push_frame(d, l, r);
        #1;
        scramble();
        load_bus.load_valid = keep;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int unsigned hits0;
        reset = 1'b1;
        load_bus.load_valid = 1'b0;
        load_bus.load_data  = '0;
        load_bus.load_len   = '0;
        load_bus.load_rep   = '0;
        #1;
        check("rst_state", {a, busy, done, load_bus.load_ready}, 4'b1001);
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        send(8'hA5, 4'd8, 4'd0, 1'b0);
        drain();
        send(8'hFF, 4'd0, 4'd0, 1'b0);
        drain();
        send(8'h3C, 4'd15, 4'd0, 1'b0);
        drain();

        hits0 = det_hits;
        send(8'h80, 4'd3, 4'd2, 1'b0);
        drain();
        check("det_hits_ge3", (det_hits - hits0 >= 3) ? 1 : 0, 1);

        for (int i = 0; i < 4; i++)
            send(8'($urandom), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 1)), (i != 3));
        drain();

        send(8'hA5, 4'd8, 4'd0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("rst_mid_frame", {a, busy, done, load_bus.load_ready}, 4'b1001);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
